seq_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier, successor to the team's fixed 4-bit combinational array multiplier. Computes a full-width `2*WIDTH`-bit product of two `WIDTH`-bit operands. It takes one partial-product step per clock, trading latency for area. A start/busy/done handshake lets a controller issue back-to-back multiplies, and an optional signed mode is compiled in by macro.

---
 rtl/seq_multiplier.sv | 153 +++++++++++++++
 tb/tb_seq_multiplier.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add multiplier, one partial-product
// step per clock. Computes a full 2*WIDTH-bit product of two WIDTH-bit
// operands with a WIDTH-cycle latency from the accepting edge to done.
//
// Optional feature macro: SIGNED_MULT_EN
//   defined   -> sgn=1 treats A/B as two's complement. Magnitudes are formed
//                at capture, the unsigned core runs on them, and the product
//                is negated on the result edge when the signs differ.
//   undefined -> sgn is ignored; all operands are unsigned.
//
// Ports:
//   clk    in   1         sole clock, rising edge
//   rst    in   1         asynchronous active-high reset
//   start  in   1         request a multiply (sampled in IDLE or DONE only)
//   A      in   WIDTH     multiplicand, captured on the accepting edge
//   B      in   WIDTH     multiplier, captured on the accepting edge
//   sgn    in   1         signed operands (only with SIGNED_MULT_EN)
//   busy   out  1         high while iterating
//   done   out  1         one-cycle pulse; P valid from this cycle onward
//   P      out  2*WIDTH   product register, holds until the next result
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               sgn,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // {accumulator, multiplier}: upper half accumulates, lower half shifts out
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     mag_a, mag_b;

`ifdef SIGNED_MULT_EN
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
  logic neg_q, neg_d;
  logic res_neg;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  // Operand conditioning at capture
  always_comb begin
`ifdef SIGNED_MULT_EN
    mag_a   = (sgn && A[WIDTH-1]) ? (~A + ONE_W) : A;
    mag_b   = (sgn && B[WIDTH-1]) ? (~B + ONE_W) : B;
    res_neg = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
`else
    mag_a = A;
    mag_b = B;
`endif
  end

  // One shift-and-add step; the WIDTH+1-bit sum keeps the carry, which
  // becomes the MSB of the shifted {carry, acc, multiplier} register.
  always_comb begin
    addend = prod_q[0] ? mcand_q : '0;
    sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step   = {sum, prod_q[WIDTH-1:1]};
`ifdef SIGNED_MULT_EN
    result = neg_q ? (~step + ONE_2W) : step;
`else
    result = step;
`endif
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef SIGNED_MULT_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = mag_a;
          prod_d  = {{WIDTH{1'b0}}, mag_b};
          cnt_d   = '0;
`ifdef SIGNED_MULT_EN
          neg_d   = res_neg;
`endif
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        prod_d = step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          p_d     = result;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef SIGNED_MULT_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
`ifdef SIGNED_MULT_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: a WIDTH=8 instance for the main
// function, reset and start-while-busy cases, and a WIDTH=4 instance for the
// back-to-back handshake. Signed cases build only with SIGNED_MULT_EN.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .sgn(sgn8),
    .busy(busy8), .done(done8), .P(p8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .sgn(sgn4),
    .busy(busy4), .done(done4), .P(p4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 40);
  endtask

  task automatic wait4(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done4 && n < 40);
  endtask

  task automatic count_done8(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done8) dones++;
    end
  endtask

  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp);
    int n;
    issue8(a, b, s);
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    wait8(n);
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_p"}, 32'(p8), 32'(exp));
    check({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; sgn4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_p", 32'(p8), 32'h0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    count_done8(20, dones);
    check("idle_no_done", 32'(dones), 32'd0);

    mul8("ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    mul8("zero_5a", 8'h00, 8'h5A, 1'b0, 16'h0000);

    // Second request mid-RUN must be ignored
    issue8(8'd7, 8'd6, 1'b0);
    tick(); tick(); tick();
    a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 4;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("busy_start_lat", 32'(n), 32'd8);
    check("busy_start_p", 32'(p8), 32'd42);
    count_done8(15, dones);
    check("busy_start_no_extra", 32'(dones), 32'd0);

    // Asynchronous reset during step 3
    issue8(8'hAB, 8'hCD, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_p", 32'(p8), 32'h0);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    tick();
    rst = 1'b0;
    count_done8(12, dones);
    check("midrst_no_done", 32'(dones), 32'd0);
    mul8("after_rst", 8'd2, 8'd3, 1'b0, 16'd6);

`ifdef SIGNED_MULT_EN
    mul8("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
    mul8("s_m1_5", 8'hFF, 8'h05, 1'b1, 16'hFFFB);
    mul8("s_127_m128", 8'h7F, 8'h80, 1'b1, 16'hC080);
    mul8("u_80_80", 8'h80, 8'h80, 1'b0, 16'h4000);
`else
    mul8("sgn_ignored", 8'hFF, 8'h05, 1'b1, 16'h04FB);
`endif

    // Back-to-back on WIDTH=4 with start held high
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    tick();
    a4 = 4'd9; b4 = 4'd3;
    wait4(n);
    check("b2b_lat1", 32'(n), 32'd4);
    check("b2b_p1", 32'(p4), 32'h00E1);
    wait4(n);
    check("b2b_gap", 32'(n), 32'd5);
    check("b2b_p2", 32'(p4), 32'h001B);
    start4 = 1'b0;
    tick();
    check("b2b_idle_busy", 32'(busy4), 32'd0);
    check("b2b_idle_done", 32'(done4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
